// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light display monitor and encoder.
// Phase codes, monitor FSM states, 7-segment digit patterns, helpers.
package tl_pkg;

    typedef enum logic [1:0] {
        PH_OFF    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_RED    = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_TRACK = 2'b10
    } state_t;

    // Active-high segments, bit0=a .. bit6=g.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Legal phase cycle: GREEN -> YELLOW -> RED -> GREEN.
    function automatic logic [1:0] next_phase(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            PH_GREEN:  n = PH_YELLOW;
            PH_YELLOW: n = PH_RED;
            PH_RED:    n = PH_GREEN;
            default:   n = PH_OFF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational 7-segment to BCD digit decoder (exact pattern match).
// Ports: seg (7-bit pattern in), digit (0..9 out), ok (pattern legal).
module seg7_dec
    import tl_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       ok
);

    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: ok    = 1'b0;
        endcase
    end

endmodule

// File: rtl/tl_display_monitor.sv
// Watches a traffic-light controller's LED phase and 2-digit countdown
// display, decoding it on each enabled tick and flagging illegal steps.
// Ports: clk, rst_n (sync, active-low), en, tick, led[1:0],
//   seg_a/seg_b[6:0] (tens/units) in; count_val[6:0], phase[1:0],
//   valid, err_seg, err_seq, err_count[7:0] out.
// Build option: define TL_MON_ERRCNT_EN for the saturating error counter;
//   otherwise err_count is tied to zero.
module tl_display_monitor
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       tick,
    input  logic [1:0] led,
    input  logic [6:0] seg_a,
    input  logic [6:0] seg_b,
    output logic [6:0] count_val,
    output logic [1:0] phase,
    output logic       valid,
    output logic       err_seg,
    output logic       err_seq,
    output logic [7:0] err_count
);

    state_t     state;
    logic [3:0] tens;
    logic [3:0] units;
    logic       ok_a;
    logic       ok_b;
    logic [6:0] new_count;
    logic       sample;
    logic       bad_seg;
    logic       seq_ok;
    logic       seq_event;

    seg7_dec u_dec_a (.seg(seg_a), .digit(tens),  .ok(ok_a));
    seg7_dec u_dec_b (.seg(seg_b), .digit(units), .ok(ok_b));

    // 10*tens = 8*tens + 2*tens; max 99 fits in 7 bits.
    assign new_count = {tens, 3'b000} + {2'b00, tens, 1'b0}
                     + {3'b000, units};

    // IDLE never samples, so a tick in the cycle en rises is dropped.
    assign sample  = en & tick & (state != ST_IDLE);
    assign bad_seg = ~ok_a | ~ok_b | (led == PH_OFF);

    always_comb begin
        if (led == phase)
            seq_ok = (new_count == count_val - 7'd1);
        else
            seq_ok = (count_val == 7'd0)
                   & (led == next_phase(phase))
                   & (new_count != 7'd0);
    end

    assign seq_event = sample & ~bad_seg & (state == ST_TRACK) & ~seq_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count_val <= 7'd0;
            phase     <= PH_OFF;
            valid     <= 1'b0;
            err_seg   <= 1'b0;
            err_seq   <= 1'b0;
        end else begin
            err_seg <= 1'b0;
            err_seq <= 1'b0;
            if (!en) begin
                state <= ST_IDLE;
                valid <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: state <= ST_SYNC;
                    ST_SYNC, ST_TRACK: begin
                        if (tick) begin
                            if (bad_seg) begin
                                err_seg <= 1'b1;
                                valid   <= 1'b0;
                                state   <= ST_SYNC;
                            end else begin
                                // A bad step still becomes the new reference.
                                count_val <= new_count;
                                phase     <= led;
                                valid     <= 1'b1;
                                err_seq   <= seq_event;
                                state     <= ST_TRACK;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef TL_MON_ERRCNT_EN
    logic err_event;
    assign err_event = sample & (bad_seg | seq_event);

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= 8'd0;
        else if (err_event && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tl_display_monitor.sv
// Self-checking bench for tl_display_monitor: directed vector table,
// randomized run against a reference model, and error-count saturation.
module tb_tl_display_monitor;

    logic       clk = 1'b0;
    logic       rst_n, en, tick;
    logic [1:0] led;
    logic [6:0] seg_a, seg_b;
    logic [6:0] count_val;
    logic [1:0] phase;
    logic       valid, err_seg, err_seq;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    tl_display_monitor dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .led(led),
        .seg_a(seg_a), .seg_b(seg_b), .count_val(count_val),
        .phase(phase), .valid(valid), .err_seg(err_seg),
        .err_seq(err_seq), .err_count(err_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int m_count, m_phase, m_valid, m_eseg, m_eseq, m_errs;
    bit m_armed, m_locked;

    function automatic logic [6:0] S(input int d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    function automatic int dec(input logic [6:0] s);
        for (int d = 0; d < 10; d++)
            if (S(d) == s) return d;
        return -1;
    endfunction

    function automatic int exp_ec(input int n);
`ifdef TL_MON_ERRCNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic model_step();
        int t, u, nc, np;
        bit legal;
        if (!rst_n) begin
            m_count = 0; m_phase = 0; m_valid = 0;
            m_eseg = 0; m_eseq = 0; m_errs = 0;
            m_armed = 0; m_locked = 0;
            return;
        end
        m_eseg = 0;
        m_eseq = 0;
        if (!en) begin
            m_valid = 0; m_armed = 0; m_locked = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (tick) begin
            t = dec(seg_a);
            u = dec(seg_b);
            np = int'(led);
            if (t < 0 || u < 0 || np == 0) begin
                m_eseg = 1; m_errs++; m_valid = 0; m_locked = 0;
            end else begin
                nc = 10 * t + u;
                if (np == m_phase)
                    legal = (nc == m_count - 1);
                else
                    legal = (m_count == 0) && (nc != 0)
                         && (np == (m_phase % 3) + 1);
                if (m_locked && !legal) begin
                    m_eseq = 1; m_errs++;
                end
                m_count = nc; m_phase = np;
                m_valid = 1; m_locked = 1;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic t,
                         input logic [1:0] l, input logic [6:0] a,
                         input logic [6:0] b);
        rst_n = r; en = e; tick = t; led = l; seg_a = a; seg_b = b;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int p,
                           input int v, input int es, input int eq,
                           input int ec);
        chk({tag, ".count_val"}, int'(count_val), c);
        chk({tag, ".phase"},     int'(phase),     p);
        chk({tag, ".valid"},     int'(valid),     v);
        chk({tag, ".err_seg"},   int'(err_seg),   es);
        chk({tag, ".err_seq"},   int'(err_seq),   eq);
        chk({tag, ".err_count"}, int'(err_count), ec);
    endtask

    typedef struct {
        logic r, e, t;
        logic [1:0] l;
        logic [6:0] a, b;
        int c, p, v, es, eq, errs;
    } vec_t;

    vec_t tab[$];

    task automatic mk(input logic r, input logic e, input logic t,
                      input logic [1:0] l, input logic [6:0] a,
                      input logic [6:0] b, input int c, input int p,
                      input int v, input int es, input int eq,
                      input int errs);
        vec_t x;
        x.r = r; x.e = e; x.t = t; x.l = l; x.a = a; x.b = b;
        x.c = c; x.p = p; x.v = v; x.es = es; x.eq = eq; x.errs = errs;
        tab.push_back(x);
    endtask

    initial begin
        int r, cnt, ph;
        logic [6:0] a, b;
        logic [1:0] l;

        // r  e  t  led    tens   units    cnt ph v es eq errs
        mk(0, 0, 0, 2'd0, S(0), S(0),     0, 0, 0, 0, 0, 0);
        mk(1, 1, 1, 2'd1, S(2), S(5),     0, 0, 0, 0, 0, 0);
        mk(1, 1, 0, 2'd1, S(2), S(5),     0, 0, 0, 0, 0, 0);
        mk(1, 1, 1, 2'd1, S(2), S(5),    25, 1, 1, 0, 0, 0);
        mk(1, 1, 1, 2'd1, S(2), S(4),    24, 1, 1, 0, 0, 0);
        mk(1, 1, 0, 2'd1, S(2), S(3),    24, 1, 1, 0, 0, 0);
        mk(1, 1, 1, 2'd1, S(2), S(2),    22, 1, 1, 0, 1, 1);
        mk(1, 1, 1, 2'd1, S(0), S(1),     1, 1, 1, 0, 1, 2);
        mk(1, 1, 1, 2'd1, S(0), S(0),     0, 1, 1, 0, 0, 2);
        mk(1, 1, 1, 2'd2, S(0), S(3),     3, 2, 1, 0, 0, 2);
        mk(1, 1, 1, 2'd2, S(0), S(2),     2, 2, 1, 0, 0, 2);
        mk(1, 1, 1, 2'd2, S(0), S(1),     1, 2, 1, 0, 0, 2);
        mk(1, 1, 1, 2'd2, S(0), S(0),     0, 2, 1, 0, 0, 2);
        mk(1, 1, 1, 2'd1, S(0), S(0),     0, 1, 1, 0, 1, 3);
        mk(1, 1, 1, 2'd3, S(0), S(9),     9, 3, 1, 0, 1, 4);
        mk(1, 1, 1, 2'd3, S(0), S(8),     8, 3, 1, 0, 0, 4);
        mk(1, 1, 1, 2'd3, S(0), 7'h00,    8, 3, 0, 1, 0, 5);
        mk(1, 1, 1, 2'd3, S(0), S(3),     3, 3, 1, 0, 0, 5);
        mk(1, 1, 1, 2'd3, S(0), S(2),     2, 3, 1, 0, 0, 5);
        mk(1, 0, 1, 2'd3, S(0), S(1),     2, 3, 0, 0, 0, 5);
        mk(1, 1, 1, 2'd3, S(0), S(1),     2, 3, 0, 0, 0, 5);
        mk(1, 1, 1, 2'd3, S(0), S(7),     7, 3, 1, 0, 0, 5);
        mk(0, 1, 1, 2'd3, S(0), S(6),     0, 0, 0, 0, 0, 0);
        mk(1, 1, 0, 2'd1, S(1), S(0),     0, 0, 0, 0, 0, 0);
        mk(1, 1, 1, 2'd1, S(1), S(0),    10, 1, 1, 0, 0, 0);
        mk(1, 1, 1, 2'd2, S(9), S(9),    99, 2, 1, 0, 1, 1);
        mk(1, 1, 1, 2'd2, S(9), S(8),    98, 2, 1, 0, 0, 1);
        mk(1, 1, 1, 2'd0, S(9), S(7),    98, 2, 0, 1, 0, 2);
        mk(1, 1, 1, 2'd3, S(0), S(0),     0, 3, 1, 0, 0, 2);
        mk(1, 1, 1, 2'd3, S(0), S(0),     0, 3, 1, 0, 1, 3);

        foreach (tab[i]) begin
            cycle(tab[i].r, tab[i].e, tab[i].t, tab[i].l,
                  tab[i].a, tab[i].b);
            chk_all($sformatf("vec%0d", i), tab[i].c, tab[i].p,
                    tab[i].v, tab[i].es, tab[i].eq, exp_ec(tab[i].errs));
        end

        // Randomized run against the model, mostly legal countdowns.
        cycle(0, 0, 0, 2'd0, S(0), S(0));
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            cnt = m_count;
            ph = (m_phase == 0) ? 1 : m_phase;
            if (r < 6) begin
                if (cnt > 0) begin
                    cnt = cnt - 1;
                end else begin
                    ph = (ph % 3) + 1;
                    cnt = int'($urandom_range(1, 99));
                end
            end else begin
                cnt = int'($urandom_range(0, 99));
                ph = int'($urandom_range(1, 3));
            end
            a = S(cnt / 10);
            b = S(cnt % 10);
            l = 2'(ph);
            if (r == 7) b = 7'($urandom);
            if (r == 8) l = 2'd0;
            if (r == 9) a = 7'($urandom);
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 29) != 0,
                  1'($urandom), l, a, b);
            chk_all("rand", m_count, m_phase, m_valid, m_eseg, m_eseq,
                    exp_ec(m_errs));
        end

        // Drive 300 segment errors to exercise counter saturation.
        cycle(0, 0, 0, 2'd0, S(0), S(0));
        cycle(1, 1, 0, 2'd1, S(0), S(0));
        for (int n = 0; n < 300; n++) begin
            cycle(1, 1, 1, 2'd1, S(5), 7'h00);
            if (n % 50 == 0)
                chk_all("sat", m_count, m_phase, m_valid, m_eseg, m_eseq,
                        exp_ec(m_errs));
        end
        chk("sat.final", int'(err_count), exp_ec(300));
        chk("sat.pulse", int'(err_seg), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tl_display_monitor.md
TL_DISPLAY_MONITOR -- requirements
Module: tl_display_monitor

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port en, input, 1, monitor enable; mirrors the controller's en.
REQ-004 SHALL have port tick, input, 1, one-cycle strobe marking one logic second; sampling point.
REQ-005 SHALL have port led, input, 2, observed phase: 00 OFF, 01 GREEN, 10 YELLOW, 11 RED.
REQ-006 SHALL have port seg_a, input, 7, tens digit, active-high, bit0=a .. bit6=g.
REQ-007 SHALL have port seg_b, input, 7, units digit, same encoding as seg_a.
REQ-008 SHALL have port count_val, output, 7, decoded display value 0..99.
REQ-009 SHALL have port phase, output, 2, last sampled led value.
REQ-010 SHALL have port valid, output, 1, high while count_val/phase reflect a legal sample.
REQ-011 SHALL have port err_seg, output, 1, one-cycle pulse on an undecodable segment pattern.
REQ-012 SHALL have port err_seq, output, 1, one-cycle pulse on an illegal count step or phase step.
REQ-013 SHALL have port err_count, output, 8, saturating total of err_seg plus err_seq events.

Function
REQ-014 SHALL decode digits 0-9 by exact 7-bit match; any other pattern is undecodable.
REQ-015 SHALL compute count_val = 10*tens + units, 7 bits wide, with no overflow possible.
REQ-016 SHALL sample inputs only in a cycle with tick=1 and en=1; outputs update on the next edge (latency 1).
REQ-017 SHALL implement FSM states IDLE, SYNC, TRACK.
REQ-018 SHALL move IDLE->SYNC when en=1.
REQ-019 SHALL, in any state, force IDLE with valid=0 on the next edge when en=0; error pulses are suppressed.
REQ-020 SHALL, in SYNC on a sampled tick with a decodable display and led!=OFF, load count_val/phase, set valid=1, and go to TRACK, with no sequence check.
REQ-021 SHALL, in TRACK with an unchanged phase, require new count = previous count - 1; otherwise pulse err_seq.
REQ-022 SHALL, in TRACK on a phase change, require previous count = 0, new phase as the legal successor (GREEN->YELLOW->RED->GREEN), and new count != 0; otherwise pulse err_seq.
REQ-023 SHALL, on an undecodable digit or led=OFF while sampling in SYNC or TRACK, pulse err_seg, clear valid, and return to SYNC.
REQ-024 SHALL, on a sequence error, still load the new sample as the reference, keep valid=1, and stay in TRACK (resynchronise).
REQ-025 SHALL pulse at most one of err_seg and err_seq per sample; err_seg has priority.
REQ-026 SHALL treat a tick arriving in the same cycle that en rises as ignored; sampling starts from the next tick.
REQ-027 SHALL hold err_count at 255 on saturation.

Reset
REQ-028 SHALL, on rst_n=0 at a clock edge, set: FSM=IDLE, count_val=0, phase=00, valid=0, err_seg=0, err_seq=0, err_count=0.
REQ-029 SHALL let reset mid-TRACK discard the reference sample; the first sample after reset is unchecked (SYNC).

Configuration
REQ-030 SHALL, with macro TL_MON_ERRCNT_EN defined, implement err_count per REQ-013/REQ-027.
REQ-031 SHALL, without TL_MON_ERRCNT_EN, tie err_count to 0 with no counter register; the error pulses are unchanged.

Structure
REQ-032 SHALL place the phase encodings (OFF/GREEN/YELLOW/RED), the FSM state encodings, and the ten 7-segment digit constants in shared package tl_pkg, also used by the display encoder.
REQ-033 SHALL implement the digit decode as sub-module seg7_dec (7-bit in -> 4-bit digit + ok flag), instantiated twice, purely combinational.

Verification
REQ-034 SHALL cover: reset, then en=1; tick with seg "2","5", led=GREEN -> next cycle count_val=25, phase=01, valid=1, no error.
REQ-035 SHALL cover: in TRACK GREEN 25, tick with 24 -> no error; tick with 22 -> err_seq pulse, count_val=22, err_count=1.
REQ-036 SHALL cover: GREEN 0 then tick YELLOW 3 -> no error; GREEN 0 then tick RED 9 -> err_seq pulse.
REQ-037 SHALL cover: seg_b=7'h00 on a tick -> err_seg pulse, valid=0, FSM=SYNC; next good tick -> valid=1, no err_seq.
REQ-038 SHALL cover: en=0 mid-TRACK -> next cycle valid=0, FSM=IDLE; rst_n=0 mid-TRACK -> all outputs 0.
REQ-039 SHALL cover: force 300 errors -> err_count=255 with the macro defined, and 0 without it.
